scara_ik_sequencer: RTL

Control FSM that sequences the shared kinematics datapath through the FK -> J -> JI -> MULT -> CONV compute chain to solve a joint move for one (x,y) target. It iterates until the Cartesian error is within tolerance or the iteration budget runs out, and accumulates per-joint step commands. It sits between the host target registers and the stepper drivers. The datapath itself (FK, Jacobian, inverse, multiply, convert) stays external and is driven only through a start/done handshake.

---
 rtl/scara_pkg.sv | 38 +++
 rtl/scara_step_accum.sv | 31 +++
 rtl/scara_ik_sequencer.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/scara_pkg.sv
// Shared types and constants for the SCARA inverse-kinematics sequencer and its datapath.
// compute_state_t is the op code seen by the external datapath.
package scara_pkg;

  typedef enum logic [2:0] {
    FK   = 3'd0,
    J    = 3'd1,
    JI   = 3'd2,
    MULT = 3'd3,
    CONV = 3'd4
  } compute_state_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FK,
    ST_J,
    ST_JI,
    ST_MULT,
    ST_CONV,
    ST_DONE,
    ST_FAULT
  } seq_state_t;

  localparam int STEP_W   = 14;
  localparam int STEP_MAX = 16383;

  // Arm lengths in position units, used by the datapath side.
  localparam int L1 = 8936;
  localparam int L2 = 7447;

  // Magnitude of a 14-bit signed error, widened so -8192 maps to +8192.
  function automatic logic [14:0] abs15(input logic [13:0] v);
    logic signed [14:0] s;
    s = {v[13], v};
    return s[14] ? 15'(-s) : 15'(s);
  endfunction

endpackage

// File: rtl/scara_step_accum.sv
// Saturating accumulator: adds a signed step delta to an unsigned joint position,
// clamping the result to 0..STEP_MAX.
module scara_step_accum
  import scara_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [STEP_W-1:0] delta,
  output logic [STEP_W-1:0] steps
);

  // Two guard bits: the sum spans -8192..24574, which a 15-bit signed value cannot hold.
  logic signed [STEP_W+1:0] sum;

  assign sum = $signed({2'b00, steps}) + $signed({{2{delta[STEP_W-1]}}, delta});

  always_ff @(posedge clk) begin
    if (reset) begin
      steps <= '0;
    end else if (en) begin
      if (sum[STEP_W+1])
        steps <= '0;
      else if (sum[STEP_W])
        steps <= STEP_W'(STEP_MAX);
      else
        steps <= sum[STEP_W-1:0];
    end
  end

endmodule

// File: rtl/scara_ik_sequencer.sv
// Sequences the shared kinematics datapath FK->J->JI->MULT->CONV per iteration until the
// Cartesian error is within TOL or MAX_ITER is spent; accumulates joint step commands.
module scara_ik_sequencer
  import scara_pkg::*;
#(
  parameter int MAX_ITER   = 16,
  parameter int TOL        = 8,
  parameter int DP_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tgt_valid,
  output logic        tgt_ready,
  input  logic [13:0] x_target,
  input  logic [13:0] y_target,
  input  logic        abort,
  output logic        dp_start,
  output logic [2:0]  dp_op,
  output logic [13:0] dp_x_target,
  output logic [13:0] dp_y_target,
  input  logic        dp_done,
  input  logic [13:0] dp_err_x,
  input  logic [13:0] dp_err_y,
  input  logic [13:0] dp_dth1,
  input  logic [13:0] dp_dth2,
  output logic [13:0] th1_steps,
  output logic [13:0] th2_steps,
  output logic        busy,
  output logic        done,
  output logic        converged,
  output logic        fault,
  output logic [7:0]  iter_count
);

  seq_state_t  state, state_nxt;
  logic        issued, issued_nxt;
  logic [7:0]  timer, timer_nxt;
  logic [7:0]  iter_nxt;
  logic        conv_nxt;
  logic        fault_nxt;
  logic        accept;
  logic        step_en;
  logic [13:0] x_lat, y_lat;
  logic        err_in_tol;

  assign err_in_tol = (abs15(dp_err_x) <= 15'(TOL)) && (abs15(dp_err_y) <= 15'(TOL));

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      issued     <= 1'b0;
      timer      <= '0;
      iter_count <= '0;
      converged  <= 1'b0;
      fault      <= 1'b0;
      x_lat      <= '0;
      y_lat      <= '0;
    end else begin
      state      <= state_nxt;
      issued     <= issued_nxt;
      timer      <= timer_nxt;
      iter_count <= iter_nxt;
      converged  <= conv_nxt;
      fault      <= fault_nxt;
      if (accept) begin
        x_lat <= x_target;
        y_lat <= y_target;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    issued_nxt = issued;
    timer_nxt  = timer;
    iter_nxt   = iter_count;
    conv_nxt   = converged;
    fault_nxt  = fault;
    dp_start   = 1'b0;
    accept     = 1'b0;
    step_en    = 1'b0;

    case (state)
      ST_IDLE: begin
        if (tgt_valid) begin
          accept     = 1'b1;
          iter_nxt   = '0;
          conv_nxt   = 1'b0;
          issued_nxt = 1'b0;
          state_nxt  = ST_FK;
        end
      end
      ST_DONE:  state_nxt = ST_IDLE;
      ST_FAULT: ;
      default: begin
        // Issue sub-phase: launch the op; a dp_done in this cycle belongs to nobody.
        if (!issued) begin
          dp_start   = 1'b1;
          issued_nxt = 1'b1;
          timer_nxt  = '0;
        end else if (dp_done) begin
          issued_nxt = 1'b0;
          case (state)
            ST_FK: begin
              if (err_in_tol) begin
                conv_nxt  = 1'b1;
                state_nxt = ST_DONE;
              end else if (iter_count == 8'(MAX_ITER)) begin
                conv_nxt  = 1'b0;
                state_nxt = ST_DONE;
              end else begin
                state_nxt = ST_J;
              end
            end
            ST_J:    state_nxt = ST_JI;
            ST_JI:   state_nxt = ST_MULT;
            ST_MULT: state_nxt = ST_CONV;
            default: begin
              step_en   = 1'b1;
              iter_nxt  = iter_count + 8'd1;
              state_nxt = ST_FK;
            end
          endcase
        end else if ({1'b0, timer} + 9'd1 == 9'(DP_TIMEOUT)) begin
          issued_nxt = 1'b0;
          fault_nxt  = 1'b1;
          state_nxt  = ST_FAULT;
        end else begin
          timer_nxt = timer + 8'd1;
        end
      end
    endcase

    // Abort overrides everything outside IDLE, including a coincident dp_done.
    if (abort && state != ST_IDLE) begin
      state_nxt  = ST_IDLE;
      issued_nxt = 1'b0;
      conv_nxt   = 1'b0;
      fault_nxt  = 1'b0;
      iter_nxt   = iter_count;
      step_en    = 1'b0;
    end
  end

  always_comb begin
    case (state)
      ST_J:    dp_op = J;
      ST_JI:   dp_op = JI;
      ST_MULT: dp_op = MULT;
      ST_CONV: dp_op = CONV;
      default: dp_op = FK;
    endcase
  end

  assign tgt_ready   = (state == ST_IDLE);
  assign busy        = (state != ST_IDLE);
  assign done        = (state == ST_DONE);
  assign dp_x_target = x_lat;
  assign dp_y_target = y_lat;

  scara_step_accum u_th1 (
    .clk   (clk),
    .reset (reset),
    .en    (step_en),
    .delta (dp_dth1),
    .steps (th1_steps)
  );

  scara_step_accum u_th2 (
    .clk   (clk),
    .reset (reset),
    .en    (step_en),
    .delta (dp_dth2),
    .steps (th2_steps)
  );

endmodule
